pl_id_stage: RTL and testbench
==============================

Name: pl_id_stage

Overview:
- ID stage of the 8-bit RISC RNS pipeline. Producer side of the IFID interface that the EX stage consumes.
- Decodes a 16-bit instruction from fetch and reads both source operands from the external per-domain register file.
- Registers op1, op2, pred_nxt_prog_ctr and the 39-bit IFID_reg control bundle.
- Owns load-use stall generation and branch flush (bubble insertion).

Parameters:
- NUM_DOMAINS, 1, number of RNS domains; operand width is NUM_DOMAINS*8, domain 1 in the MSBs.
- PROG_CTR_WID, 10, program counter width.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- if_valid  in  1  fetch presents a valid instruction this cycle.
- if_instr  in  16  instruction word.
- if_pc  in  PROG_CTR_WID  PC of if_instr.
- branch_taken_EX  in  1  EX resolved a taken jump; flush.
- rf_raddr1, rf_raddr2  out  3  register-file read addresses (combinational from if_instr).
- rf_rdata1, rf_rdata2  in  NUM_DOMAINS*8  same-cycle read data.
- id_stall  out  1  fetch must hold if_instr/if_pc.
- op1, op2  out  NUM_DOMAINS*8  registered operands.
- pred_nxt_prog_ctr  out  PROG_CTR_WID  registered if_pc+1 (wraps modulo 2^PROG_CTR_WID).
- IFID_reg  out  39  registered control bundle.
- ex_rd  out  3  registered destination register of the instruction now in EX.

Behaviour:
- Encoding: [15:11] opcode, [10:8] rd, [7:5] rs1, [4:2] rs2, [7:0] addr8 for LD/ST/jumps.
- rf_raddr1 = rs1, rf_raddr2 = rs2. For ST, rf_raddr2 = rd (the store data register).
- IFID_reg bit map:
  - [0] invalidate_fetch_instr
  - [1] branch_taken_EX
  - [2] add
  - [3] or_op
  - [4] not_op
  - [5] and_bitwise
  - [6] or_bitwise
  - [7] not_bitwise
  - [8] and_op
  - [9] carry_in
  - [10] en_op2_complement
  - [11] jump
  - [12] compare
  - [13] shift_left
  - [14] lgcl_or_bitwse_T
  - [15] store
  - [16] load
  - [17] write_to_regfile
  - [18] jump_gt
  - [19] jump_lt
  - [20] jump_eq
  - [21] jump_carry
  - [22] unconditional_jump
  - [30:23] ld_mem_addr
  - [38:31] st_mem_addr
- Opcodes:
  - 0 NOP: all zero.
  - 1 ADD: [2],[17].
  - 2 SUB: [2],[9],[10],[17].
  - 3 AND: [8],[14],[17].
  - 4 OR: [3],[14],[17].
  - 5 NOT: [4],[14],[17].
  - 6 ANDB: [5],[14],[17].
  - 7 ORB: [6],[14],[17].
  - 8 NOTB: [7],[14],[17].
  - 9 SHL: [13],[17].
  - 10 CMP: [2],[9],[10],[12].
  - 11 LD: [16],[17], ld_mem_addr=addr8.
  - 12 ST: [15], st_mem_addr=addr8.
  - 13 JMP: [11],[22], ld_mem_addr=addr8 (target).
  - 14 JGT: [11],[18], target as JMP.
  - 15 JLT: [11],[19], target as JMP.
  - 16 JEQ: [11],[20], target as JMP.
  - 17 JC: [11],[21], target as JMP.
  - 18-31 illegal: decoded as NOP.
- Latency: one cycle; all outputs update on rising clk.
- Bubble: IFID_reg = 39'b1 (only bit0 set); op1 = op2 = 0; pred_nxt_prog_ctr holds its value.
- Load-use hazard:
  - Condition: registered IFID_reg[16]=1 and ex_rd matches any source the current instruction reads; sources per opcode are rs1, rs2, or rd for ST.
  - Response: id_stall=1 (combinational) and a bubble is registered.
  - Fetch holds; the instruction re-decodes next cycle and proceeds, since the bubble clears the hazard.
- Flush: branch_taken_EX=1 registers a bubble with bit[1]=1; the current if_instr is discarded.
- Flush wins over stall: id_stall=0 whenever branch_taken_EX=1.
- if_valid=0 (and no flush): register a bubble, id_stall=0.
- Reset (asserted, any time including mid-stall): IFID_reg=39'b1, op1=op2=0, pred_nxt_prog_ctr=0, ex_rd=0, id_stall=0, illegal state cleared.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined:
  - Adds output illegal_op (1 bit), sticky until reset, set the cycle after an illegal opcode is accepted while if_valid=1 and no flush.
  - The illegal instruction is still issued as a bubble.
- Undefined: no port; illegal opcodes silently become NOPs.

Decomposition:
- Package pl_pkg: opcode localparams, IFID_reg bit-index localparams, bundle width 39, BUBBLE constant.
- One sub-module, pl_id_decode: purely combinational opcode → 39-bit bundle and source-use flags. The stage wraps it with hazard logic and registers.

Test Plan:
- Reset low mid-stream → IFID_reg=39'h1, op1/op2=0, id_stall=0. Release, ADD r1,r2,r3 with rdata 8'h05/8'h03 → next cycle IFID_reg bits[2],[17] set, op1=8'h05, op2=8'h03.
- SUB then CMP → bits {2,9,10,17} then {2,9,10,12}, write bit clear for CMP.
- LD r4,addr 8'h3C then ADD r5,r4,r1 → ld_mem_addr=8'h3C; id_stall=1 one cycle; bubble; then ADD issued with bit0=0.
- LD r4 followed by branch_taken_EX=1 with a dependent ADD → no stall, bubble with bits[0],[1] set.
- ST r2 to 8'hA0 → rf_raddr2=2, bit15 set, st_mem_addr=8'hA0. JEQ target 8'h12 → bits[11],[20], ld_mem_addr=8'h12.
- Opcode 5'd25 with if_valid=1 → bubble; with ILLEGAL_OP_TRAP_EN, illegal_op=1 and stays 1 until reset. if_pc at max wraps pred_nxt_prog_ctr to 0.

Source files
------------

// File: rtl/pl_pkg.sv
// -----------------------------------------------------------------------------
// pl_pkg
// Shared definitions for the 8-bit RISC RNS pipeline ID stage:
//   - 5-bit opcode values
//   - bit positions inside the 39-bit IFID_reg control bundle
//   - bubble constants (plain bubble and flush bubble)
// -----------------------------------------------------------------------------
package pl_pkg;

    localparam int IFID_W = 39;

    typedef logic [IFID_W-1:0] ifid_t;

    // Opcodes (instr[15:11]); 18..31 are illegal
    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_NOT  = 5'd5;
    localparam logic [4:0] OP_ANDB = 5'd6;
    localparam logic [4:0] OP_ORB  = 5'd7;
    localparam logic [4:0] OP_NOTB = 5'd8;
    localparam logic [4:0] OP_SHL  = 5'd9;
    localparam logic [4:0] OP_CMP  = 5'd10;
    localparam logic [4:0] OP_LD   = 5'd11;
    localparam logic [4:0] OP_ST   = 5'd12;
    localparam logic [4:0] OP_JMP  = 5'd13;
    localparam logic [4:0] OP_JGT  = 5'd14;
    localparam logic [4:0] OP_JLT  = 5'd15;
    localparam logic [4:0] OP_JEQ  = 5'd16;
    localparam logic [4:0] OP_JC   = 5'd17;

    // IFID_reg bit positions
    localparam int B_INV   = 0;   // invalidate_fetch_instr
    localparam int B_BR    = 1;   // branch_taken_EX
    localparam int B_ADD   = 2;
    localparam int B_OR    = 3;
    localparam int B_NOT   = 4;
    localparam int B_ANDB  = 5;
    localparam int B_ORB   = 6;
    localparam int B_NOTB  = 7;
    localparam int B_AND   = 8;
    localparam int B_CIN   = 9;   // carry_in
    localparam int B_CMPL  = 10;  // en_op2_complement
    localparam int B_JUMP  = 11;
    localparam int B_CMP   = 12;
    localparam int B_SHL   = 13;
    localparam int B_LGC   = 14;  // lgcl_or_bitwse_T
    localparam int B_ST    = 15;
    localparam int B_LD    = 16;
    localparam int B_WR    = 17;  // write_to_regfile
    localparam int B_JGT   = 18;
    localparam int B_JLT   = 19;
    localparam int B_JEQ   = 20;
    localparam int B_JC    = 21;
    localparam int B_UJ    = 22;  // unconditional_jump
    localparam int LD_ADDR_LSB = 23;  // [30:23] ld_mem_addr / jump target
    localparam int ST_ADDR_LSB = 31;  // [38:31] st_mem_addr

    localparam ifid_t BUBBLE       = 39'h1;
    localparam ifid_t FLUSH_BUBBLE = 39'h3;  // bubble that also carries bit[1]

endpackage

// File: rtl/pl_id_decode.sv
// -----------------------------------------------------------------------------
// pl_id_decode
// Purely combinational opcode decoder.
// Ports:
//   opcode  in  5   instr[15:11]
//   addr8   in  8   instr[7:0], memory address / jump target
//   bundle  out 39  IFID control bundle for this instruction (bit0 never set)
//   use_rs1 out 1   instruction reads rs1
//   use_rs2 out 1   instruction reads rs2
//   use_rd  out 1   instruction reads rd (store data)
//   illegal out 1   opcode 18..31; bundle is all zero in that case
// -----------------------------------------------------------------------------
module pl_id_decode
    import pl_pkg::*;
(
    input  logic [4:0]        opcode,
    input  logic [7:0]        addr8,
    output logic [IFID_W-1:0] bundle,
    output logic              use_rs1,
    output logic              use_rs2,
    output logic              use_rd,
    output logic              illegal
);

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned; that is what keeps this block free of latches.
    always_comb begin
        bundle  = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_ADD: begin
                bundle[B_ADD] = 1'b1; bundle[B_WR] = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_SUB: begin
                bundle[B_ADD] = 1'b1; bundle[B_CIN] = 1'b1;
                bundle[B_CMPL] = 1'b1; bundle[B_WR] = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_AND: begin
                bundle[B_AND] = 1'b1; bundle[B_LGC] = 1'b1; bundle[B_WR] = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_OR: begin
                bundle[B_OR] = 1'b1; bundle[B_LGC] = 1'b1; bundle[B_WR] = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_NOT: begin
                bundle[B_NOT] = 1'b1; bundle[B_LGC] = 1'b1; bundle[B_WR] = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_ANDB: begin
                bundle[B_ANDB] = 1'b1; bundle[B_LGC] = 1'b1; bundle[B_WR] = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_ORB: begin
                bundle[B_ORB] = 1'b1; bundle[B_LGC] = 1'b1; bundle[B_WR] = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_NOTB: begin
                bundle[B_NOTB] = 1'b1; bundle[B_LGC] = 1'b1; bundle[B_WR] = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_SHL: begin
                bundle[B_SHL] = 1'b1; bundle[B_WR] = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_CMP: begin
                bundle[B_ADD] = 1'b1; bundle[B_CIN] = 1'b1;
                bundle[B_CMPL] = 1'b1; bundle[B_CMP] = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_LD: begin
                bundle[B_LD] = 1'b1; bundle[B_WR] = 1'b1;
                bundle[LD_ADDR_LSB +: 8] = addr8;
            end
            OP_ST: begin
                bundle[B_ST] = 1'b1;
                bundle[ST_ADDR_LSB +: 8] = addr8;
                use_rd = 1'b1;
            end
            OP_JMP: begin
                bundle[B_JUMP] = 1'b1; bundle[B_UJ] = 1'b1;
                bundle[LD_ADDR_LSB +: 8] = addr8;
            end
            OP_JGT: begin
                bundle[B_JUMP] = 1'b1; bundle[B_JGT] = 1'b1;
                bundle[LD_ADDR_LSB +: 8] = addr8;
            end
            OP_JLT: begin
                bundle[B_JUMP] = 1'b1; bundle[B_JLT] = 1'b1;
                bundle[LD_ADDR_LSB +: 8] = addr8;
            end
            OP_JEQ: begin
                bundle[B_JUMP] = 1'b1; bundle[B_JEQ] = 1'b1;
                bundle[LD_ADDR_LSB +: 8] = addr8;
            end
            OP_JC: begin
                bundle[B_JUMP] = 1'b1; bundle[B_JC] = 1'b1;
                bundle[LD_ADDR_LSB +: 8] = addr8;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pl_id_stage.sv
// -----------------------------------------------------------------------------
// pl_id_stage
// ID stage of the 8-bit RISC RNS pipeline: decodes the fetched instruction,
// reads both operands from the external register file, handles load-use
// stalls and branch flushes, and registers the IFID bundle for EX.
// Optional feature macro: ILLEGAL_OP_TRAP_EN (adds sticky illegal_op output).
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   if_valid, if_instr,  fetched instruction and its PC
//   if_pc
//   branch_taken_EX      EX resolved a taken jump: flush
//   rf_raddr1/2          register-file read addresses (combinational)
//   rf_rdata1/2          same-cycle read data
//   id_stall             fetch must hold its instruction
//   op1, op2             registered operands
//   pred_nxt_prog_ctr    registered if_pc+1
//   IFID_reg             registered 39-bit control bundle
//   ex_rd                registered rd of the instruction now in EX
//   illegal_op           (ILLEGAL_OP_TRAP_EN only) sticky illegal-opcode flag
// -----------------------------------------------------------------------------
module pl_id_stage
    import pl_pkg::*;
#(
    parameter int NUM_DOMAINS  = 1,
    parameter int PROG_CTR_WID = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      if_valid,
    input  logic [15:0]               if_instr,
    input  logic [PROG_CTR_WID-1:0]   if_pc,
    input  logic                      branch_taken_EX,
    output logic [2:0]                rf_raddr1,
    output logic [2:0]                rf_raddr2,
    input  logic [NUM_DOMAINS*8-1:0]  rf_rdata1,
    input  logic [NUM_DOMAINS*8-1:0]  rf_rdata2,
    output logic                      id_stall,
    output logic [NUM_DOMAINS*8-1:0]  op1,
    output logic [NUM_DOMAINS*8-1:0]  op2,
    output logic [PROG_CTR_WID-1:0]   pred_nxt_prog_ctr,
    output logic [IFID_W-1:0]         IFID_reg,
    output logic [2:0]                ex_rd
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic                      illegal_op
`endif
);

    logic [2:0]        rd, rs1, rs2;
    logic [IFID_W-1:0] dec_bundle;
    logic              use_rs1, use_rs2, use_rd, dec_illegal;
    logic              load_use, issue;

    assign rd  = if_instr[10:8];
    assign rs1 = if_instr[7:5];
    assign rs2 = if_instr[4:2];

    pl_id_decode u_decode (
        .opcode  (if_instr[15:11]),
        .addr8   (if_instr[7:0]),
        .bundle  (dec_bundle),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2),
        .use_rd  (use_rd),
        .illegal (dec_illegal)
    );

    // A store reads its data register through port 2.
    assign rf_raddr1 = rs1;
    assign rf_raddr2 = dec_bundle[B_ST] ? rd : rs2;

    // The load now in EX returns its data too late for the instruction in ID.
    assign load_use = if_valid && IFID_reg[B_LD] &&
                      ((use_rs1 && (rs1 == ex_rd)) ||
                       (use_rs2 && (rs2 == ex_rd)) ||
                       (use_rd  && (rd  == ex_rd)));

    // A flush discards the instruction anyway, so it never needs to stall.
    assign id_stall = load_use && !branch_taken_EX;

    assign issue = if_valid && !branch_taken_EX && !load_use && !dec_illegal;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: every register here has a reset value; this stage holds no arrays,
    // so nothing is deliberately left unreset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IFID_reg          <= BUBBLE;
            op1               <= '0;
            op2               <= '0;
            pred_nxt_prog_ctr <= '0;
            ex_rd             <= '0;
        end else if (issue) begin
            IFID_reg          <= dec_bundle;
            op1               <= rf_rdata1;
            op2               <= rf_rdata2;
            pred_nxt_prog_ctr <= if_pc + PROG_CTR_WID'(1);
            ex_rd             <= rd;
        end else begin
            // Bubble: flush, stall, no valid instruction, or illegal opcode.
            // pred_nxt_prog_ctr keeps the last issued value.
            IFID_reg <= branch_taken_EX ? FLUSH_BUBBLE : BUBBLE;
            op1      <= '0;
            op2      <= '0;
            ex_rd    <= '0;
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_op <= 1'b0;
        end else if (if_valid && !branch_taken_EX && dec_illegal) begin
            illegal_op <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pl_id_stage.sv
// -----------------------------------------------------------------------------
// tb_pl_id_stage
// Table-driven bench for pl_id_stage with a scoreboard queue for registered
// outputs, plus hand-written reset-mid-stall and illegal-opcode sequences.
// Optional feature macro: ILLEGAL_OP_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_pl_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [9:0]  if_pc;
    logic        branch_taken_EX;
    logic [2:0]  rf_raddr1, rf_raddr2;
    logic [7:0]  rf_rdata1, rf_rdata2;
    logic        id_stall;
    logic [7:0]  op1, op2;
    logic [9:0]  pred_nxt_prog_ctr;
    logic [38:0] IFID_reg;
    logic [2:0]  ex_rd;
`ifdef ILLEGAL_OP_TRAP_EN
    logic        illegal_op;
`endif

    pl_id_stage #(.NUM_DOMAINS(1), .PROG_CTR_WID(10)) dut (
        .clk               (clk),
        .reset             (reset),
        .if_valid          (if_valid),
        .if_instr          (if_instr),
        .if_pc             (if_pc),
        .branch_taken_EX   (branch_taken_EX),
        .rf_raddr1         (rf_raddr1),
        .rf_raddr2         (rf_raddr2),
        .rf_rdata1         (rf_rdata1),
        .rf_rdata2         (rf_rdata2),
        .id_stall          (id_stall),
        .op1               (op1),
        .op2               (op2),
        .pred_nxt_prog_ctr (pred_nxt_prog_ctr),
        .IFID_reg          (IFID_reg),
        .ex_rd             (ex_rd)
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        .illegal_op        (illegal_op)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Instruction builders: register form and addr8 form.
    function automatic logic [15:0] ir(input int op, input int rd, input int rs1, input int rs2);
        return {op[4:0], rd[2:0], rs1[2:0], rs2[2:0], 2'b00};
    endfunction
    function automatic logic [15:0] ia(input int op, input int rd, input int addr);
        return {op[4:0], rd[2:0], addr[7:0]};
    endfunction
    function automatic logic [38:0] b(input int i);
        return 39'd1 << i;
    endfunction
    function automatic logic [38:0] la(input int a);
        return 39'(a[7:0]) << 23;
    endfunction
    function automatic logic [38:0] sa(input int a);
        return 39'(a[7:0]) << 31;
    endfunction

    typedef struct {
        logic        valid;
        logic [15:0] instr;
        logic [9:0]  pc;
        logic        br;
        logic [7:0]  rd1, rd2;
        logic        stall;
        logic [2:0]  ra1, ra2;
        logic [38:0] ifid;
        logic [7:0]  op1, op2;
        logic [9:0]  pnpc;
        logic [2:0]  exrd;
    } vec_t;

    typedef struct {
        logic [38:0] ifid;
        logic [7:0]  op1, op2;
        logic [9:0]  pnpc;
        logic [2:0]  exrd;
    } exp_t;

    exp_t sb[$];
    vec_t vec[24];

    task automatic drive(input logic v, input logic [15:0] ins, input logic [9:0] pc,
                         input logic br, input logic [7:0] d1, input logic [7:0] d2);
        if_valid = v; if_instr = ins; if_pc = pc; branch_taken_EX = br;
        rf_rdata1 = d1; rf_rdata2 = d2;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " IFID_reg"}, 64'(IFID_reg), 64'h1);
        check({tag, " op1"}, 64'(op1), 64'h0);
        check({tag, " op2"}, 64'(op2), 64'h0);
        check({tag, " pnpc"}, 64'(pred_nxt_prog_ctr), 64'h0);
        check({tag, " ex_rd"}, 64'(ex_rd), 64'h0);
        check({tag, " id_stall"}, 64'(id_stall), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        //        valid instr              pc      br    rd1    rd2    stall ra1   ra2   ifid                         op1    op2    pnpc    exrd
        vec[0]  = '{1'b1, ir(1,1,2,3),     10'd5,  1'b0, 8'h05, 8'h03, 1'b0, 3'd2, 3'd3, b(2)|b(17),                  8'h05, 8'h03, 10'd6,  3'd1};
        vec[1]  = '{1'b1, ir(2,2,1,3),     10'd6,  1'b0, 8'h0A, 8'h04, 1'b0, 3'd1, 3'd3, b(2)|b(9)|b(10)|b(17),       8'h0A, 8'h04, 10'd7,  3'd2};
        vec[2]  = '{1'b1, ir(10,0,1,2),    10'd7,  1'b0, 8'h11, 8'h22, 1'b0, 3'd1, 3'd2, b(2)|b(9)|b(10)|b(12),       8'h11, 8'h22, 10'd8,  3'd0};
        vec[3]  = '{1'b1, ir(3,3,4,5),     10'd8,  1'b0, 8'h0F, 8'hF0, 1'b0, 3'd4, 3'd5, b(8)|b(14)|b(17),            8'h0F, 8'hF0, 10'd9,  3'd3};
        vec[4]  = '{1'b1, ir(4,3,4,5),     10'd9,  1'b0, 8'h3C, 8'hC3, 1'b0, 3'd4, 3'd5, b(3)|b(14)|b(17),            8'h3C, 8'hC3, 10'd10, 3'd3};
        vec[5]  = '{1'b1, ia(11,4,'h3C),   10'd10, 1'b0, 8'hAA, 8'hBB, 1'b0, 3'd1, 3'd7, b(16)|b(17)|la('h3C),        8'hAA, 8'hBB, 10'd11, 3'd4};
        vec[6]  = '{1'b1, ir(1,5,4,1),     10'd11, 1'b0, 8'h07, 8'h02, 1'b1, 3'd4, 3'd1, 39'h1,                       8'h00, 8'h00, 10'd11, 3'd0};
        vec[7]  = '{1'b1, ir(1,5,4,1),     10'd11, 1'b0, 8'h07, 8'h02, 1'b0, 3'd4, 3'd1, b(2)|b(17),                  8'h07, 8'h02, 10'd12, 3'd5};
        vec[8]  = '{1'b1, ia(11,4,'h3C),   10'd12, 1'b0, 8'h00, 8'h00, 1'b0, 3'd1, 3'd7, b(16)|b(17)|la('h3C),        8'h00, 8'h00, 10'd13, 3'd4};
        vec[9]  = '{1'b1, ir(1,5,4,1),     10'd13, 1'b1, 8'h07, 8'h02, 1'b0, 3'd4, 3'd1, 39'h3,                       8'h00, 8'h00, 10'd13, 3'd0};
        vec[10] = '{1'b1, ia(11,2,'h40),   10'd13, 1'b0, 8'h00, 8'h00, 1'b0, 3'd2, 3'd0, b(16)|b(17)|la('h40),        8'h00, 8'h00, 10'd14, 3'd2};
        vec[11] = '{1'b1, ia(12,2,'hA0),   10'd14, 1'b0, 8'h00, 8'h5A, 1'b1, 3'd5, 3'd2, 39'h1,                       8'h00, 8'h00, 10'd14, 3'd0};
        vec[12] = '{1'b1, ia(12,2,'hA0),   10'd14, 1'b0, 8'h00, 8'h5A, 1'b0, 3'd5, 3'd2, b(15)|sa('hA0),              8'h00, 8'h5A, 10'd15, 3'd2};
        vec[13] = '{1'b1, ia(11,3,'h10),   10'd15, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 3'd4, b(16)|b(17)|la('h10),        8'h00, 8'h00, 10'd16, 3'd3};
        vec[14] = '{1'b1, ir(1,1,2,3),     10'd16, 1'b0, 8'h01, 8'h02, 1'b1, 3'd2, 3'd3, 39'h1,                       8'h00, 8'h00, 10'd16, 3'd0};
        vec[15] = '{1'b1, ir(1,1,2,3),     10'd16, 1'b0, 8'h01, 8'h02, 1'b0, 3'd2, 3'd3, b(2)|b(17),                  8'h01, 8'h02, 10'd17, 3'd1};
        vec[16] = '{1'b1, ia(11,3,'h10),   10'd17, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 3'd4, b(16)|b(17)|la('h10),        8'h00, 8'h00, 10'd18, 3'd3};
        vec[17] = '{1'b1, ir(5,1,2,3),     10'd18, 1'b0, 8'h33, 8'h44, 1'b0, 3'd2, 3'd3, b(4)|b(14)|b(17),            8'h33, 8'h44, 10'd19, 3'd1};
        vec[18] = '{1'b1, ia(16,0,'h12),   10'd19, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 3'd4, b(11)|b(20)|la('h12),        8'h00, 8'h00, 10'd20, 3'd0};
        vec[19] = '{1'b0, ir(1,1,2,3),     10'd20, 1'b0, 8'h99, 8'h88, 1'b0, 3'd2, 3'd3, 39'h1,                       8'h00, 8'h00, 10'd20, 3'd0};
        vec[20] = '{1'b1, ir(9,7,6,0),     10'd1023,1'b0,8'h80, 8'h00, 1'b0, 3'd6, 3'd0, b(13)|b(17),                 8'h80, 8'h00, 10'd0,  3'd7};
        vec[21] = '{1'b1, ir(8,1,2,0),     10'd0,  1'b0, 8'h5A, 8'h00, 1'b0, 3'd2, 3'd0, b(7)|b(14)|b(17),            8'h5A, 8'h00, 10'd1,  3'd1};
        vec[22] = '{1'b1, ia(13,0,'h55),   10'd1,  1'b0, 8'h00, 8'h00, 1'b0, 3'd2, 3'd5, b(11)|b(22)|la('h55),        8'h00, 8'h00, 10'd2,  3'd0};
        vec[23] = '{1'b1, 16'h0000,        10'd2,  1'b0, 8'h12, 8'h34, 1'b0, 3'd0, 3'd0, 39'h0,                       8'h12, 8'h34, 10'd3,  3'd0};

        // Reset asserted from time zero with arbitrary inputs present.
        reset = 1'b0;
        drive(1'b1, ir(1,1,2,3), 10'd5, 1'b0, 8'hFF, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b1;

        // Table: combinational outputs checked before the edge, registered
        // outputs popped from the scoreboard after it.
        for (int i = 0; i < 24; i++) begin
            drive(vec[i].valid, vec[i].instr, vec[i].pc, vec[i].br, vec[i].rd1, vec[i].rd2);
            sb.push_back('{vec[i].ifid, vec[i].op1, vec[i].op2, vec[i].pnpc, vec[i].exrd});
            #1;
            check($sformatf("v%0d id_stall", i), 64'(id_stall), 64'(vec[i].stall));
            check($sformatf("v%0d rf_raddr1", i), 64'(rf_raddr1), 64'(vec[i].ra1));
            check($sformatf("v%0d rf_raddr2", i), 64'(rf_raddr2), 64'(vec[i].ra2));
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL v%0d scoreboard: queue empty, expected one entry", i);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d IFID_reg", i), 64'(IFID_reg), 64'(e.ifid));
                check($sformatf("v%0d op1", i), 64'(op1), 64'(e.op1));
                check($sformatf("v%0d op2", i), 64'(op2), 64'(e.op2));
                check($sformatf("v%0d pnpc", i), 64'(pred_nxt_prog_ctr), 64'(e.pnpc));
                check($sformatf("v%0d ex_rd", i), 64'(ex_rd), 64'(e.exrd));
            end
        end

        // Reset asserted in the middle of a load-use stall.
        drive(1'b1, ia(11,4,'h3C), 10'd3, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        drive(1'b1, ir(1,5,4,1), 10'd4, 1'b0, 8'h07, 8'h02);
        #1;
        check("midstall id_stall before reset", 64'(id_stall), 64'h1);
        reset = 1'b0;
        #1;
        check_reset_state("midstall");
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset IFID_reg", 64'(IFID_reg), 64'(b(2)|b(17)));
        check("post-reset op1", 64'(op1), 64'h07);
        check("post-reset pnpc", 64'(pred_nxt_prog_ctr), 64'd5);

        // Illegal opcode 25 is issued as a bubble; with the trap, the flag sticks.
        drive(1'b1, {5'd25, 11'h0}, 10'd8, 1'b0, 8'h11, 8'h22);
        #1;
        check("illegal id_stall", 64'(id_stall), 64'h0);
        @(posedge clk);
        #1;
        check("illegal IFID_reg", 64'(IFID_reg), 64'h1);
        check("illegal op1", 64'(op1), 64'h0);
`ifdef ILLEGAL_OP_TRAP_EN
        check("illegal_op set", 64'(illegal_op), 64'h1);
`endif
        drive(1'b1, ir(1,1,2,3), 10'd9, 1'b0, 8'h01, 8'h01);
        repeat (2) @(posedge clk);
        #1;
        check("after illegal IFID_reg", 64'(IFID_reg), 64'(b(2)|b(17)));
`ifdef ILLEGAL_OP_TRAP_EN
        check("illegal_op sticky", 64'(illegal_op), 64'h1);
`endif
        reset = 1'b0;
        #1;
        check("final reset IFID_reg", 64'(IFID_reg), 64'h1);
`ifdef ILLEGAL_OP_TRAP_EN
        check("illegal_op cleared", 64'(illegal_op), 64'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
